// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  // Access FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Which requester owns the access in flight
  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  localparam int DEFAULT_MEM_LATENCY  = 2;
  localparam int DEFAULT_STARVE_LIMIT = 2;

  // Starve counter width: wide enough to hold STARVE_LIMIT, never zero bits
  function automatic int starve_width(input int limit);
    return $clog2(limit + 2);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Request/response bundle between the fetch port, data port, RAM and arbiter.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  // Requester / RAM side
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter_arb_priority.sv
// Winner selection: data normally wins, fetch wins once data has starved it.
module arb_priority
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_W     = 2,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                if_req,
  input  logic                mem_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant,
  output owner_t              owner
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  // Combinational priority pick between the two pending requests
  always_comb begin
    grant = 1'b0;
    owner = OWNER_DATA;
    if (if_req && (!mem_req || (starve_cnt == LIMIT))) begin
      grant = 1'b1;
      owner = OWNER_FETCH;
    end else if (mem_req) begin
      grant = 1'b1;
      owner = OWNER_DATA;
    end else begin
      grant = 1'b0;
      owner = OWNER_DATA;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port RAM arbiter shared by an instruction fetch port and a data port.
// One access in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// MEM_LATENCY is expected in 1..7 (3-bit latency counter).
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  unified_mem_arbiter_if.slave  bus
);

  localparam int              SW         = starve_width(STARVE_LIMIT);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0]      LAT_LOAD   = 3'(MEM_LATENCY - 1);

  // State and latched request
  state_t        state, state_n;
  owner_t        owner, owner_n;
  logic          we, we_n;
  logic [2:0]    lat_cnt, lat_n;
  logic [SW-1:0] starve_cnt, starve_n;

  // Output registers
  logic        if_gnt_q, if_gnt_n;
  logic        if_valid_q, if_valid_n;
  logic [31:0] if_rdata_q, if_rdata_n;
  logic        mem_gnt_q, mem_gnt_n;
  logic        mem_valid_q, mem_valid_n;
  logic [31:0] mem_rdata_q, mem_rdata_n;
  logic        ram_en_q, ram_en_n;
  logic        ram_we_q, ram_we_n;
  logic [31:0] ram_addr_q, ram_addr_n;
  logic [31:0] ram_wdata_q, ram_wdata_n;
  logic        busy_q, busy_n;

  logic   win_grant;
  owner_t win_owner;

  arb_priority #(
    .STARVE_W     (SW),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb_priority (
    .if_req     (bus.if_req),
    .mem_req    (bus.mem_req),
    .starve_cnt (starve_cnt),
    .grant      (win_grant),
    .owner      (win_owner)
  );

  // Next-state, counter and next-output computation
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    we_n        = we;
    lat_n       = lat_cnt;
    starve_n    = starve_cnt;
    if_gnt_n    = 1'b0;
    if_valid_n  = 1'b0;
    if_rdata_n  = 32'h0000_0000;
    mem_gnt_n   = 1'b0;
    mem_valid_n = 1'b0;
    mem_rdata_n = 32'h0000_0000;
    ram_en_n    = 1'b0;
    ram_we_n    = 1'b0;
    ram_addr_n  = 32'h0000_0000;
    ram_wdata_n = 32'h0000_0000;

    case (state)
      ST_IDLE: begin
        if (win_grant) begin
          // Latch the winner; the RAM strobe registers hold its address/data
          owner_n    = win_owner;
          state_n    = ST_ISSUE;
          ram_en_n   = 1'b1;
          if (win_owner == OWNER_DATA) begin
            we_n        = bus.mem_we;
            mem_gnt_n   = 1'b1;
            ram_we_n    = bus.mem_we;
            ram_addr_n  = bus.mem_addr;
            ram_wdata_n = bus.mem_we ? bus.mem_wdata : 32'h0000_0000;
            if (bus.if_req) begin
              starve_n = (starve_cnt == STARVE_MAX) ? starve_cnt : (starve_cnt + SW'(1));
            end else begin
              starve_n = '0;
            end
          end else begin
            we_n        = 1'b0;
            if_gnt_n    = 1'b1;
            ram_we_n    = 1'b0;
            ram_addr_n  = bus.if_addr;
            ram_wdata_n = 32'h0000_0000;
            starve_n    = '0;
          end
        end else begin
          state_n  = ST_IDLE;
          starve_n = bus.if_req ? starve_cnt : '0;
        end
      end
      ST_ISSUE: begin
        // WAIT spans MEM_LATENCY cycles so the capture lines up with RAM data
        lat_n   = LAT_LOAD;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == 3'd0) begin
          state_n = ST_RESP;
          if (owner == OWNER_DATA) begin
            mem_valid_n = 1'b1;
            mem_rdata_n = we ? 32'h0000_0000 : bus.ram_rdata;
          end else begin
            if_valid_n = 1'b1;
            if_rdata_n = bus.ram_rdata;
          end
        end else begin
          lat_n = lat_cnt - 3'd1;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State, counters and registered outputs; reset abandons any access
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      owner       <= OWNER_FETCH;
      we          <= 1'b0;
      lat_cnt     <= 3'd0;
      starve_cnt  <= '0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      mem_gnt_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'h0000_0000;
      ram_wdata_q <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      we          <= we_n;
      lat_cnt     <= lat_n;
      starve_cnt  <= starve_n;
      if_gnt_q    <= if_gnt_n;
      if_valid_q  <= if_valid_n;
      if_rdata_q  <= if_rdata_n;
      mem_gnt_q   <= mem_gnt_n;
      mem_valid_q <= mem_valid_n;
      mem_rdata_q <= mem_rdata_n;
      ram_en_q    <= ram_en_n;
      ram_we_q    <= ram_we_n;
      ram_addr_q  <= ram_addr_n;
      ram_wdata_q <= ram_wdata_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_gnt   = mem_gnt_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.busy      = busy_q;

endmodule
